elevator_scheduler: RTL
=======================

ELEVATOR_SCHEDULER -- requirements
Module: elevator_scheduler

Interface
REQ-001 Parameter N_FLOORS, default 3, SHALL set the number of served floors, legal range 2..8, floor 0 is the bottom floor.
REQ-002 Parameter DWELL_TICKS, default 4, SHALL set the door-open dwell in tick pulses, legal range 1..15.
REQ-003 CLK  input  1  single system clock; all state changes on its rising edge.
REQ-004 RST  input  1  asynchronous, active-low reset.
REQ-005 tick  input  1  one-CLK-wide timing pulse (slow time base); only the dwell counter uses it.
REQ-006 interior_panel  input  N_FLOORS  car buttons, bit i = floor i, level-sensitive.
REQ-007 exterior_panel  input  N_FLOORS  hall buttons, bit i = floor i, level-sensitive.
REQ-008 arrive  input  1  one-CLK pulse from the motion datapath: car has reached the next floor in the commanded direction.
REQ-009 engine  output  2  00 off, 10 up, 11 down.
REQ-010 doors  output  N_FLOORS  one-hot open door, bit i = floor i; all zero while moving.
REQ-011 floor  output  3  current floor index.
REQ-012 pending  output  N_FLOORS  latched outstanding requests.
REQ-013 direction  output  1  1 up, 0 down; travel or last travel direction.

Function
REQ-014 States SHALL be IDLE, DWELL, MOVE_UP, MOVE_DOWN; engine SHALL be 10 only in MOVE_UP, 11 only in MOVE_DOWN, else 00.
REQ-015 pending[i] SHALL set on the CLK edge after (interior_panel[i] | exterior_panel[i]) is high, unless i == floor and the state is IDLE or DWELL.
REQ-016 A press at the current floor in IDLE or DWELL SHALL go to or stay in DWELL and reload the dwell counter to DWELL_TICKS.
REQ-017 In DWELL the counter SHALL decrement on each tick; at tick with counter == 1 the state SHALL leave DWELL on that edge.
REQ-018 Leaving DWELL or sitting in IDLE, the next state SHALL be chosen SCAN-style: continue in direction if any pending bit lies beyond floor that way; else reverse if any pending bit lies the other way; else IDLE.
REQ-019 Entering MOVE_UP/MOVE_DOWN SHALL clear doors and set direction to 1/0 on the same edge.
REQ-020 On arrive in MOVE_UP (MOVE_DOWN), floor SHALL increment (decrement) on that edge; if pending[new floor] is set, that bit SHALL clear and the state SHALL go to DWELL with doors one-hot at the new floor and counter = DWELL_TICKS.
REQ-021 If pending[new floor] is clear after arrive, the state SHALL stay in the move state with engine unchanged.
REQ-022 arrive in MOVE_UP at floor N_FLOORS-1, in MOVE_DOWN at floor 0, or in IDLE/DWELL SHALL be ignored; floor never wraps.
REQ-023 A request for the floor being reached, arriving on the same edge as arrive, SHALL be served at that stop and SHALL NOT remain pending.
REQ-024 Simultaneous requests for several floors SHALL all latch in one edge; requests never clear except by service or reset.
REQ-025 IDLE SHALL keep doors one-hot at floor; decision latency IDLE -> move SHALL be one CLK after pending rises.

Reset
REQ-026 RST low SHALL force, asynchronously: state IDLE, floor 0, doors one-hot bit 0, engine 00, pending 0, direction 1, counter 0.
REQ-027 Reset asserted mid-move SHALL abandon the trip and all pending requests; the motion datapath is reset alongside.

Configuration
REQ-028 With macro SCHED_DOOR_HOLD_EN defined, a 1-bit input door_hold SHALL exist; while it is high in DWELL, the counter SHALL reload to DWELL_TICKS every CLK.
REQ-029 Without SCHED_DOOR_HOLD_EN the port SHALL be absent and dwell SHALL always expire after DWELL_TICKS ticks.

Verification
REQ-030 Reset, then press interior_panel=3'b100 -> pending=100, engine=10 next CLK; two arrive pulses -> floor=2, doors=100, engine=00, pending=000.
REQ-031 At floor 0 moving up to 2, press exterior_panel=3'b010 before first arrive -> stop at floor 1, doors=010, DWELL 4 ticks, then resume engine=10.
REQ-032 At floor 1 going up with pending=101 -> serve floor 2 first, then reverse, engine=11, serve floor 0.
REQ-033 In DWELL at floor 1, press floor 1 after 3 ticks -> counter reloads, door open 4 more ticks, pending stays 000.
REQ-034 Assert RST between arrive pulses during MOVE_DOWN -> floor=0, doors=001, engine=00, pending=000 immediately.
REQ-035 With SCHED_DOOR_HOLD_EN, hold door_hold high 20 ticks -> doors stay open; release -> closes exactly 4 ticks later.

Source files
------------

// File: rtl/elevator_scheduler.sv
// ----------------------------------------------------------------------------
// elevator_scheduler
//
// Purpose: SCAN-style elevator controller. It latches hall and car requests,
// commands the motion datapath up or down, stops at requested floors, and
// holds the door open for a tick-based dwell time.
//
// Ports:
//   CLK             system clock, rising edge
//   RST             asynchronous reset, active low
//   tick            one-CLK timing pulse; drives only the dwell counter
//   interior_panel  car buttons, bit i = floor i, level-sensitive
//   exterior_panel  hall buttons, bit i = floor i, level-sensitive
//   arrive          one-CLK pulse: car reached the next floor
//   door_hold       (only with SCHED_DOOR_HOLD_EN) keeps the door open
//   engine          00 off, 10 up, 11 down
//   doors           one-hot open door; all zero while moving
//   floor           current floor index
//   pending         latched outstanding requests
//   direction       1 up, 0 down (travel or last travel direction)
//
// Optional feature: define SCHED_DOOR_HOLD_EN to add the door_hold input.
// While door_hold is high in DWELL, the dwell counter reloads every CLK.
//
// States:
//   state     | meaning
//   IDLE      | stopped, door open at floor, no request to travel for
//   DWELL     | stopped, door open, dwell counter running on tick
//   MOVE_UP   | engine driving up, door closed
//   MOVE_DOWN | engine driving down, door closed
// ----------------------------------------------------------------------------
module elevator_scheduler #(
    parameter int N_FLOORS    = 3,
    parameter int DWELL_TICKS = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                tick,
    input  logic [N_FLOORS-1:0] interior_panel,
    input  logic [N_FLOORS-1:0] exterior_panel,
    input  logic                arrive,
`ifdef SCHED_DOOR_HOLD_EN
    input  logic                door_hold,
`endif
    output logic [1:0]          engine,
    output logic [N_FLOORS-1:0] doors,
    output logic [2:0]          floor,
    output logic [N_FLOORS-1:0] pending,
    output logic                direction
);

    typedef enum logic [1:0] {IDLE, DWELL, MOVE_UP, MOVE_DOWN} state_t;

    localparam logic [2:0]          TOP_FLOOR  = 3'(N_FLOORS - 1);
    localparam logic [3:0]          DWELL_LOAD = 4'(DWELL_TICKS);
    localparam logic [N_FLOORS-1:0] DOOR_RST   = N_FLOORS'(1);

    state_t              state_q, state_d;
    logic [2:0]          floor_q, floor_d;
    logic [N_FLOORS-1:0] doors_q, doors_d;
    logic [N_FLOORS-1:0] pending_q, pending_d;
    logic                direction_q, direction_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [1:0]          engine_q, engine_d;

    logic [N_FLOORS-1:0] req;
    logic [N_FLOORS-1:0] here;
    logic [N_FLOORS-1:0] next_hot;
    logic                at_rest;
    logic                up_avail;
    logic                down_avail;
    logic                hold_w;
    state_t              scan;

    function automatic logic [N_FLOORS-1:0] onehot(input logic [2:0] f);
        logic [N_FLOORS-1:0] v;
        v = '0;
        for (int i = 0; i < N_FLOORS; i++) begin
            v[i] = (f == 3'(i));
        end
        return v;
    endfunction

    function automatic logic any_above(input logic [2:0] f, input logic [N_FLOORS-1:0] p);
        logic r;
        r = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (3'(i) > f) r = r | p[i];
        end
        return r;
    endfunction

    function automatic logic any_below(input logic [2:0] f, input logic [N_FLOORS-1:0] p);
        logic r;
        r = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (3'(i) < f) r = r | p[i];
        end
        return r;
    endfunction

    always_comb begin
`ifdef SCHED_DOOR_HOLD_EN
        hold_w = door_hold;
`else
        hold_w = 1'b0;
`endif
        state_d     = state_q;
        floor_d     = floor_q;
        cnt_d       = cnt_q;
        direction_d = direction_q;
        next_hot    = '0;

        req     = interior_panel | exterior_panel;
        here    = onehot(floor_q);
        at_rest = (state_q == IDLE) || (state_q == DWELL);

        // A press for the floor we are stopped at is served by the open door
        // and never becomes pending.
        pending_d = pending_q | (req & ~(at_rest ? here : '0));

        up_avail   = any_above(floor_q, pending_q);
        down_avail = any_below(floor_q, pending_q);

        // SCAN: keep going the same way while work remains there, else reverse.
        if (direction_q) begin
            scan = up_avail ? MOVE_UP : (down_avail ? MOVE_DOWN : IDLE);
        end else begin
            scan = down_avail ? MOVE_DOWN : (up_avail ? MOVE_UP : IDLE);
        end

        case (state_q)
            IDLE: begin
                if (|(req & here)) begin
                    state_d = DWELL;
                    cnt_d   = DWELL_LOAD;
                end else begin
                    state_d = scan;
                end
            end
            DWELL: begin
                if ((|(req & here)) || hold_w) begin
                    cnt_d = DWELL_LOAD;
                end else if (tick) begin
                    if (cnt_q == 4'd1) begin
                        state_d = scan;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            MOVE_UP: begin
                if (arrive && (floor_q != TOP_FLOOR)) begin
                    floor_d  = floor_q + 3'd1;
                    next_hot = onehot(floor_d);
                    // pending_d already includes a same-edge press for this floor.
                    if (|(pending_d & next_hot)) begin
                        pending_d = pending_d & ~next_hot;
                        state_d   = DWELL;
                        cnt_d     = DWELL_LOAD;
                    end
                end
            end
            MOVE_DOWN: begin
                if (arrive && (floor_q != 3'd0)) begin
                    floor_d  = floor_q - 3'd1;
                    next_hot = onehot(floor_d);
                    if (|(pending_d & next_hot)) begin
                        pending_d = pending_d & ~next_hot;
                        state_d   = DWELL;
                        cnt_d     = DWELL_LOAD;
                    end
                end
            end
        endcase

        // Outputs are registered from the next state so they change on the
        // same edge as the state itself.
        case (state_d)
            MOVE_UP: begin
                engine_d    = 2'b10;
                doors_d     = '0;
                direction_d = 1'b1;
            end
            MOVE_DOWN: begin
                engine_d    = 2'b11;
                doors_d     = '0;
                direction_d = 1'b0;
            end
            default: begin
                engine_d = 2'b00;
                doors_d  = onehot(floor_d);
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            floor_q     <= 3'd0;
            doors_q     <= DOOR_RST;
            pending_q   <= '0;
            direction_q <= 1'b1;
            cnt_q       <= '0;
            engine_q    <= 2'b00;
        end else begin
            state_q     <= state_d;
            floor_q     <= floor_d;
            doors_q     <= doors_d;
            pending_q   <= pending_d;
            direction_q <= direction_d;
            cnt_q       <= cnt_d;
            engine_q    <= engine_d;
        end
    end

    assign engine    = engine_q;
    assign doors     = doors_q;
    assign floor     = floor_q;
    assign pending   = pending_q;
    assign direction = direction_q;

endmodule
